// File: rtl/traffic_pkg.sv
// Shared light-code definitions for the traffic-light monitor.
// Codes are one-hot: bit2=red, bit1=yellow, bit0=green.
package traffic_pkg;

  typedef logic [2:0] light_t;

  localparam light_t LIGHT_RED    = 3'b100;
  localparam light_t LIGHT_YELLOW = 3'b010;
  localparam light_t LIGHT_GREEN  = 3'b001;

  function automatic logic is_legal_code(input light_t code);
    return (code == LIGHT_RED) || (code == LIGHT_YELLOW) || (code == LIGHT_GREEN);
  endfunction

  // Only the forward rotation red->green->yellow->red is allowed.
  function automatic logic legal_transition(input light_t from_code, input light_t to_code);
    return ((from_code == LIGHT_RED)    && (to_code == LIGHT_GREEN))  ||
           ((from_code == LIGHT_GREEN)  && (to_code == LIGHT_YELLOW)) ||
           ((from_code == LIGHT_YELLOW) && (to_code == LIGHT_RED));
  endfunction

endpackage

// File: rtl/light_dir_checker.sv
// Per-direction tracker: previous code, dwell counter and completed-cycle counter.
// Reports this sample's encoding, sequence, timing and stuck failures combinationally.
module light_dir_checker
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 3,
  parameter int MIN_YELLOW = 1,
  parameter int MAX_HOLD   = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [2:0]       code,
  output logic             enc_fail,
  output logic             seq_fail,
  output logic             tim_fail,
  output logic             stuck_fail,
  output logic             active,
  output logic [CNT_W-1:0] cycles
);

  localparam int DW = $clog2(MAX_HOLD + 1);
  localparam logic [DW-1:0] MAX_HOLD_W   = DW'(MAX_HOLD);
  localparam logic [DW-1:0] MIN_GREEN_W  = DW'(MIN_GREEN);
  localparam logic [DW-1:0] MIN_YELLOW_W = DW'(MIN_YELLOW);
  localparam logic [DW-1:0] ONE_W        = DW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  light_t           prev_q, prev_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             code_ok;
  logic             rg_entry;

  always_comb begin
    prev_d     = prev_q;
    dwell_d    = dwell_q;
    valid_d    = valid_q;
    enc_fail   = 1'b0;
    seq_fail   = 1'b0;
    tim_fail   = 1'b0;
    stuck_fail = 1'b0;
    rg_entry   = 1'b0;
    code_ok    = is_legal_code(code);
    active     = code_ok && (code != LIGHT_RED);

    // An illegal code freezes tracking so the next legal code is judged against the last good one.
    if (!code_ok) begin
      enc_fail = 1'b1;
    end else if (!valid_q) begin
      valid_d = 1'b1;
      prev_d  = code;
      dwell_d = ONE_W;
    end else if (code == prev_q) begin
      if (dwell_q < MAX_HOLD_W) begin
        dwell_d    = dwell_q + ONE_W;
        stuck_fail = (dwell_d == MAX_HOLD_W);
      end
    end else begin
      seq_fail = !legal_transition(prev_q, code);
      tim_fail = ((prev_q == LIGHT_GREEN)  && (dwell_q < MIN_GREEN_W)) ||
                 ((prev_q == LIGHT_YELLOW) && (dwell_q < MIN_YELLOW_W));
      rg_entry = (prev_q == LIGHT_RED) && (code == LIGHT_GREEN);
      prev_d   = code;
      dwell_d  = ONE_W;
    end

    cycles_d = cycles_q;
    if (rg_entry) begin
      if (clr) begin
        cycles_d = CNT_ONE;
      end else if (cycles_q != CNT_MAX) begin
        cycles_d = cycles_q + CNT_ONE;
      end
    end else if (clr) begin
      cycles_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= LIGHT_RED;
      dwell_q  <= '0;
      valid_q  <= 1'b0;
      cycles_q <= '0;
    end else begin
      prev_q   <= prev_d;
      dwell_q  <= dwell_d;
      valid_q  <= valid_d;
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive safety monitor for the ns/ew traffic-light outputs: sticky error flags,
// a one-cycle error pulse and per-direction completed-phase counters.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 3,
  parameter int MIN_YELLOW = 1,
  parameter int MAX_HOLD   = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [2:0]       ns,
  input  logic [2:0]       ew,
  output logic             err_encoding,
  output logic             err_conflict,
  output logic             err_sequence,
  output logic             err_timing,
  output logic             err_stuck,
  output logic             err_pulse,
  output logic [CNT_W-1:0] ns_cycles,
  output logic [CNT_W-1:0] ew_cycles
);

  logic ns_enc, ns_seq, ns_tim, ns_stuck, ns_active;
  logic ew_enc, ew_seq, ew_tim, ew_stuck, ew_active;

  logic fail_enc, fail_conf, fail_seq, fail_tim, fail_stuck, fail_any;

  logic enc_q, enc_d;
  logic conf_q, conf_d;
  logic seq_q, seq_d;
  logic tim_q, tim_d;
  logic stuck_q, stuck_d;
  logic pulse_q, pulse_d;

  light_dir_checker #(
    .MIN_GREEN (MIN_GREEN),
    .MIN_YELLOW(MIN_YELLOW),
    .MAX_HOLD  (MAX_HOLD),
    .CNT_W     (CNT_W)
  ) u_ns (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .code      (ns),
    .enc_fail  (ns_enc),
    .seq_fail  (ns_seq),
    .tim_fail  (ns_tim),
    .stuck_fail(ns_stuck),
    .active    (ns_active),
    .cycles    (ns_cycles)
  );

  light_dir_checker #(
    .MIN_GREEN (MIN_GREEN),
    .MIN_YELLOW(MIN_YELLOW),
    .MAX_HOLD  (MAX_HOLD),
    .CNT_W     (CNT_W)
  ) u_ew (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .code      (ew),
    .enc_fail  (ew_enc),
    .seq_fail  (ew_seq),
    .tim_fail  (ew_tim),
    .stuck_fail(ew_stuck),
    .active    (ew_active),
    .cycles    (ew_cycles)
  );

  // A fresh failure outranks clr so a violation coinciding with a clear is never lost.
  always_comb begin
    fail_enc   = ns_enc | ew_enc;
    fail_conf  = ns_active & ew_active;
    fail_seq   = ns_seq | ew_seq;
    fail_tim   = ns_tim | ew_tim;
    fail_stuck = ns_stuck | ew_stuck;
    fail_any   = fail_enc | fail_conf | fail_seq | fail_tim | fail_stuck;

    enc_d   = (enc_q   & ~clr) | fail_enc;
    conf_d  = (conf_q  & ~clr) | fail_conf;
    seq_d   = (seq_q   & ~clr) | fail_seq;
    tim_d   = (tim_q   & ~clr) | fail_tim;
    stuck_d = (stuck_q & ~clr) | fail_stuck;
    pulse_d = fail_any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_q   <= 1'b0;
      conf_q  <= 1'b0;
      seq_q   <= 1'b0;
      tim_q   <= 1'b0;
      stuck_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      enc_q   <= enc_d;
      conf_q  <= conf_d;
      seq_q   <= seq_d;
      tim_q   <= tim_d;
      stuck_q <= stuck_d;
      pulse_q <= pulse_d;
    end
  end

  assign err_encoding = enc_q;
  assign err_conflict = conf_q;
  assign err_sequence = seq_q;
  assign err_timing   = tim_q;
  assign err_stuck    = stuck_q;
  assign err_pulse    = pulse_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor: vector table, hand-written corner sequences,
// then randomized traffic checked against a colour-level reference model.
module tb_traffic_light_monitor;

  localparam int MIN_GREEN  = 3;
  localparam int MIN_YELLOW = 1;
  localparam int MAX_HOLD   = 16;
  localparam int CNT_W      = 8;
  localparam int CNT_SAT    = (1 << CNT_W) - 1;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic [2:0]       ns, ew;
  logic             err_encoding, err_conflict, err_sequence, err_timing, err_stuck, err_pulse;
  logic [CNT_W-1:0] ns_cycles, ew_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .MIN_GREEN (MIN_GREEN),
    .MIN_YELLOW(MIN_YELLOW),
    .MAX_HOLD  (MAX_HOLD),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .ns          (ns),
    .ew          (ew),
    .err_encoding(err_encoding),
    .err_conflict(err_conflict),
    .err_sequence(err_sequence),
    .err_timing  (err_timing),
    .err_stuck   (err_stuck),
    .err_pulse   (err_pulse),
    .ns_cycles   (ns_cycles),
    .ew_cycles   (ew_cycles)
  );

  // Reference model in colour terms: 0=red, 1=yellow, 2=green, -1=illegal code.
  int m_valid[2];
  int m_prev[2];
  int m_dwell[2];
  int m_cnt[2];
  bit m_enc, m_conf, m_seq, m_tim, m_stk, m_pulse;
  int succ[3] = '{2, 0, 1};

  function automatic int color_of(input logic [2:0] c);
    case (c)
      3'b100:  return 0;
      3'b010:  return 1;
      3'b001:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0;
      m_prev[d]  = 0;
      m_dwell[d] = 0;
      m_cnt[d]   = 0;
    end
    {m_enc, m_conf, m_seq, m_tim, m_stk, m_pulse} = '0;
  endtask

  task automatic model_step(input logic [2:0] c0, input logic [2:0] c1, input logic cl);
    int col;
    int cols[2];
    bit f_enc, f_conf, f_seq, f_tim, f_stk;
    bit rg[2];
    cols[0] = color_of(c0);
    cols[1] = color_of(c1);
    {f_enc, f_conf, f_seq, f_tim, f_stk} = '0;
    for (int d = 0; d < 2; d++) begin
      col   = cols[d];
      rg[d] = 1'b0;
      if (col < 0) begin
        f_enc = 1'b1;
      end else if (m_valid[d] == 0) begin
        m_valid[d] = 1;
        m_prev[d]  = col;
        m_dwell[d] = 1;
      end else if (col == m_prev[d]) begin
        if (m_dwell[d] < MAX_HOLD) begin
          m_dwell[d]++;
          if (m_dwell[d] == MAX_HOLD) f_stk = 1'b1;
        end
      end else begin
        if (col != succ[m_prev[d]]) f_seq = 1'b1;
        if (m_prev[d] == 2 && m_dwell[d] < MIN_GREEN)  f_tim = 1'b1;
        if (m_prev[d] == 1 && m_dwell[d] < MIN_YELLOW) f_tim = 1'b1;
        if (m_prev[d] == 0 && col == 2) rg[d] = 1'b1;
        m_prev[d]  = col;
        m_dwell[d] = 1;
      end
    end
    f_conf = (cols[0] > 0) && (cols[1] > 0);
    m_enc  = (m_enc  && !cl) || f_enc;
    m_conf = (m_conf && !cl) || f_conf;
    m_seq  = (m_seq  && !cl) || f_seq;
    m_tim  = (m_tim  && !cl) || f_tim;
    m_stk  = (m_stk  && !cl) || f_stk;
    m_pulse = f_enc || f_conf || f_seq || f_tim || f_stk;
    for (int d = 0; d < 2; d++) begin
      if (rg[d]) begin
        if (cl) m_cnt[d] = 0;
        if (m_cnt[d] < CNT_SAT) m_cnt[d]++;
      end else if (cl) begin
        m_cnt[d] = 0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one sample, let the edge take it, then compare 1 time unit later.
  task automatic applyStimulus(input logic [2:0] n, input logic [2:0] e, input logic c);
    ns  = n;
    ew  = e;
    clr = c;
    @(posedge clk);
    model_step(n, e, c);
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_enc"},   err_encoding, m_enc);
    checkOutput({tag, "_conf"},  err_conflict, m_conf);
    checkOutput({tag, "_seq"},   err_sequence, m_seq);
    checkOutput({tag, "_tim"},   err_timing,   m_tim);
    checkOutput({tag, "_stuck"}, err_stuck,    m_stk);
    checkOutput({tag, "_pulse"}, err_pulse,    m_pulse);
    checkOutput({tag, "_nsc"},   ns_cycles,    m_cnt[0]);
    checkOutput({tag, "_ewc"},   ew_cycles,    m_cnt[1]);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_flags"}, {err_encoding, err_conflict, err_sequence, err_timing, err_stuck}, 0);
    checkOutput({tag, "_pulse"}, err_pulse, 0);
    checkOutput({tag, "_nsc"},   ns_cycles, 0);
    checkOutput({tag, "_ewc"},   ew_cycles, 0);
  endtask

  // Reset is asserted between edges so the asynchronous clear is observed directly.
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    checkAllZero(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [2:0] nextLegal(input logic [2:0] c);
    case (c)
      R:       return G;
      G:       return Y;
      Y:       return R;
      default: return R;
    endcase
  endfunction

  typedef struct {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       clr;
    logic [4:0] flags;
    logic       pulse;
    int         nsc;
    int         ewc;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int pulses;
    logic [2:0] cur[2];
    logic       rclr;
    int r;

    rst_n = 1'b0;
    clr   = 1'b0;
    ns    = R;
    ew    = R;

    // flags = {encoding, conflict, sequence, timing, stuck}
    tbl[0]  = '{R, R, 1'b0, 5'b00000, 1'b0, 0, 0};
    tbl[1]  = '{G, R, 1'b0, 5'b00000, 1'b0, 1, 0};
    tbl[2]  = '{G, R, 1'b0, 5'b00000, 1'b0, 1, 0};
    tbl[3]  = '{G, R, 1'b0, 5'b00000, 1'b0, 1, 0};
    tbl[4]  = '{Y, R, 1'b0, 5'b00000, 1'b0, 1, 0};
    tbl[5]  = '{R, R, 1'b0, 5'b00000, 1'b0, 1, 0};
    tbl[6]  = '{R, G, 1'b0, 5'b00000, 1'b0, 1, 1};
    tbl[7]  = '{R, G, 1'b0, 5'b00000, 1'b0, 1, 1};
    tbl[8]  = '{R, G, 1'b0, 5'b00000, 1'b0, 1, 1};
    tbl[9]  = '{R, Y, 1'b0, 5'b00000, 1'b0, 1, 1};
    tbl[10] = '{R, R, 1'b0, 5'b00000, 1'b0, 1, 1};
    tbl[11] = '{G, G, 1'b0, 5'b01000, 1'b1, 2, 2};
    tbl[12] = '{G, G, 1'b1, 5'b01000, 1'b1, 0, 0};
    tbl[13] = '{Y, R, 1'b0, 5'b01110, 1'b1, 0, 0};
    tbl[14] = '{R, R, 1'b1, 5'b00000, 1'b0, 0, 0};
    tbl[15] = '{3'b011, R, 1'b0, 5'b10000, 1'b1, 0, 0};
    tbl[16] = '{G, R, 1'b0, 5'b10000, 1'b0, 1, 0};

    doReset("reset0");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].ns, tbl[i].ew, tbl[i].clr);
      checkOutput($sformatf("tbl%0d_flags", i),
                  {err_encoding, err_conflict, err_sequence, err_timing, err_stuck}, tbl[i].flags);
      checkOutput($sformatf("tbl%0d_pulse", i), err_pulse, tbl[i].pulse);
      checkOutput($sformatf("tbl%0d_nsc", i),   ns_cycles, tbl[i].nsc);
      checkOutput($sformatf("tbl%0d_ewc", i),   ew_cycles, tbl[i].ewc);
    end

    // red->yellow is an illegal skip, but red carries no minimum dwell
    doReset("reset1");
    applyStimulus(R, R, 1'b0);
    applyStimulus(Y, R, 1'b0);
    checkOutput("redyel_seq",   err_sequence, 1);
    checkOutput("redyel_tim",   err_timing,   0);
    checkOutput("redyel_pulse", err_pulse,    1);

    // one-cycle green then yellow: legal order, too short
    doReset("reset2");
    applyStimulus(R, R, 1'b0);
    applyStimulus(G, R, 1'b0);
    applyStimulus(Y, R, 1'b0);
    checkOutput("shortg_tim", err_timing,   1);
    checkOutput("shortg_seq", err_sequence, 0);
    checkOutput("shortg_nsc", ns_cycles,    1);

    // ew held red while ns rotates legally; stuck appears on the 16th sample only
    doReset("reset3");
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      case (i % 5)
        0:       applyStimulus(R, R, 1'b0);
        4:       applyStimulus(Y, R, 1'b0);
        default: applyStimulus(G, R, 1'b0);
      endcase
      if (err_pulse) pulses++;
      if (i == 14) checkOutput("stuck_early", err_stuck, 0);
      if (i == 15) checkOutput("stuck_set",   err_stuck, 1);
    end
    checkOutput("stuck_pulses", pulses, 1);
    checkOutput("stuck_hold",   err_stuck, 1);
    checkOutput("stuck_other",  {err_encoding, err_conflict, err_sequence, err_timing}, 0);
    checkOutput("stuck_nsc",    ns_cycles, 4);

    // clr alone clears; clr with a fresh conflict keeps the flag and restarts the counter at 1
    doReset("reset4");
    applyStimulus(G, Y, 1'b0);
    checkOutput("clr_conf_set", err_conflict, 1);
    applyStimulus(G, R, 1'b1);
    checkOutput("clr_conf_cleared", err_conflict, 0);
    checkOutput("clr_pulse_low",    err_pulse,    0);
    applyStimulus(G, G, 1'b1);
    checkOutput("clr_conf_wins", err_conflict, 1);
    checkOutput("clr_pulse_hi",  err_pulse,    1);
    checkOutput("clr_ewc_one",   ew_cycles,    1);
    checkOutput("clr_nsc_zero",  ns_cycles,    0);

    // reset mid-green; next sample (yellow) must be treated as a first sample
    doReset("midreset");
    applyStimulus(Y, R, 1'b0);
    checkOutput("post_reset_seq", err_sequence, 0);
    checkOutput("post_reset_all",
                {err_encoding, err_conflict, err_sequence, err_timing, err_stuck, err_pulse}, 0);

    // randomized traffic against the reference model
    doReset("reset5");
    cur[0] = R;
    cur[1] = R;
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        r = $urandom_range(0, 99);
        if (r < 60) begin
          cur[d] = cur[d];
        end else if (r < 88) begin
          cur[d] = nextLegal(cur[d]);
        end else if (r < 96) begin
          case ($urandom_range(0, 2))
            0:       cur[d] = R;
            1:       cur[d] = Y;
            default: cur[d] = G;
          endcase
        end else begin
          cur[d] = 3'($urandom_range(0, 7));
        end
      end
      rclr = ($urandom_range(0, 31) == 0);
      applyStimulus(cur[0], cur[1], rclr);
      checkModel("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
